// File: rtl/tube_pkg.sv
// Constants shared by the two Tube data FIFOs (host-to-parasite and parasite-to-host).
package tube_pkg;

   localparam logic [7:0] TUBE_EMPTY_BYTE         = 8'hAA;
   localparam int         TUBE_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/tube_fifo_ram.sv
// DEPTH x 8 register array: one synchronous write port, one asynchronous read port.
module tube_fifo_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // NOTE: the array has no reset on purpose; occupancy lives in the pointers
   // and count, so stale contents are never observed and the array stays plain storage.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hp_fifo.sv
// Host-to-parasite Tube data FIFO: pointers, occupancy, flags and strobe qualification.
// Optional two-byte availability mode is enabled by defining HP_FIFO_TWO_BYTE_EN.
module hp_fifo
   import tube_pkg::*;
#(
   parameter int DEPTH = TUBE_FIFO_DEPTH_DEFAULT,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        h_phi2_en,
   input  logic        h_selectData,
   input  logic        h_rdnw,
   input  logic [7:0]  h_data,
   output logic        h_full,
   output logic        h_overflow,
   input  logic        p_phi2_en,
   input  logic        p_selectData,
   input  logic        p_rd,
   output logic [7:0]  p_data,
   output logic        p_data_available,
   input  logic        p_two_byte,
   output logic [AW:0] count
);

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [7:0]    head_byte;
   logic          push;
   logic          pop;
   logic          push_ok;
   logic          pop_ok;
   logic          is_full;
   logic          is_empty;

   assign is_full  = (count == CNT_FULL);
   assign is_empty = (count == '0);

   assign push = h_phi2_en & h_selectData & ~h_rdnw;
   assign pop  = p_phi2_en & p_selectData & p_rd;

   // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
   assign pop_ok  = pop  & ~rst & ~is_empty;
   assign push_ok = push & ~rst & (~is_full | pop_ok);

   tube_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr),
      .wdata (h_data),
      .raddr (rd_ptr),
      .rdata (head_byte)
   );

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         h_overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push_ok && !pop_ok) begin
            count <= count + CNT_ONE;
         end else if (pop_ok && !push_ok) begin
            count <= count - CNT_ONE;
         end
         if (push && !push_ok) begin
            h_overflow <= 1'b1;
         end
      end
   end

   assign p_data = is_empty ? TUBE_EMPTY_BYTE : head_byte;

`ifdef HP_FIFO_TWO_BYTE_EN
   localparam logic [AW:0] CNT_PAIR      = (AW+1)'(2);
   localparam logic [AW:0] CNT_PAIR_FULL = (AW+1)'(DEPTH - 1);

   // In pair mode the host must only see room for a complete pair of bytes.
   assign h_full           = p_two_byte ? (count >= CNT_PAIR_FULL) : is_full;
   assign p_data_available = p_two_byte ? (count >= CNT_PAIR) : ~is_empty;
`else
   logic unused_two_byte;

   assign unused_two_byte  = p_two_byte;
   assign h_full           = is_full;
   assign p_data_available = ~is_empty;
`endif

endmodule

// File: tb/tb_hp_fifo.sv
// Self-checking bench for hp_fifo: directed scenarios plus random traffic against a queue model.
module tb_hp_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          h_phi2_en;
   logic          h_selectData;
   logic          h_rdnw;
   logic [7:0]    h_data;
   logic          h_full;
   logic          h_overflow;
   logic          p_phi2_en;
   logic          p_selectData;
   logic          p_rd;
   logic [7:0]    p_data;
   logic          p_data_available;
   logic          p_two_byte;
   logic [AW:0]   count;

   logic [7:0] model_q [$];
   bit         model_ovf;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   hp_fifo #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .h_phi2_en        (h_phi2_en),
      .h_selectData     (h_selectData),
      .h_rdnw           (h_rdnw),
      .h_data           (h_data),
      .h_full           (h_full),
      .h_overflow       (h_overflow),
      .p_phi2_en        (p_phi2_en),
      .p_selectData     (p_selectData),
      .p_rd             (p_rd),
      .p_data           (p_data),
      .p_data_available (p_data_available),
      .p_two_byte       (p_two_byte),
      .count            (count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit pair_mode();
`ifdef HP_FIFO_TWO_BYTE_EN
      return p_two_byte;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_outputs(input string tag);
      int          n;
      logic [7:0]  exp_data;
      logic        exp_avail;
      logic        exp_full;
      n         = model_q.size();
      exp_data  = (n != 0) ? model_q[0] : 8'hAA;
      exp_avail = pair_mode() ? (n >= 2) : (n != 0);
      exp_full  = pair_mode() ? (n >= DEPTH - 1) : (n == DEPTH);
      check({tag, ":p_data"},    32'(p_data),           32'(exp_data));
      check({tag, ":avail"},     32'(p_data_available), 32'(exp_avail));
      check({tag, ":h_full"},    32'(h_full),           32'(exp_full));
      check({tag, ":overflow"},  32'(h_overflow),       32'(model_ovf));
      check({tag, ":count"},     32'(count),            32'(n));
   endtask

   // One clock with raw bus fields; the model applies the FIFO rules to its queue.
   task automatic drive(input string tag, input bit hen, input bit hsel, input bit hrdnw,
                        input logic [7:0] d, input bit pen, input bit psel, input bit prd);
      bit push;
      bit pop;
      bit pop_ok;
      bit push_ok;
      h_phi2_en    = hen;
      h_selectData = hsel;
      h_rdnw       = hrdnw;
      h_data       = d;
      p_phi2_en    = pen;
      p_selectData = psel;
      p_rd         = prd;
      @(posedge clk);
      push    = hen & hsel & ~hrdnw;
      pop     = pen & psel & prd;
      pop_ok  = pop && (model_q.size() != 0);
      push_ok = push && ((model_q.size() != DEPTH) || pop_ok);
      if (pop_ok)            void'(model_q.pop_front());
      if (push_ok)           model_q.push_back(d);
      if (push && !push_ok)  model_ovf = 1'b1;
      #1;
      check_outputs(tag);
      h_phi2_en = 1'b0;
      p_phi2_en = 1'b0;
   endtask

   task automatic cycle(input string tag, input bit push, input bit pop, input logic [7:0] d);
      drive(tag, push, 1'b1, 1'b0, d, pop, 1'b1, 1'b1);
   endtask

   task automatic do_reset(input bit with_ops);
      rst          = 1'b1;
      h_phi2_en    = with_ops;
      h_selectData = with_ops;
      h_rdnw       = 1'b0;
      h_data       = 8'hEE;
      p_phi2_en    = with_ops;
      p_selectData = with_ops;
      p_rd         = with_ops;
      @(posedge clk);
      model_q.delete();
      model_ovf = 1'b0;
      #1;
      check_outputs("reset");
      check("reset:count_zero", 32'(count), 32'd0);
      check("reset:p_data_aa",  32'(p_data), 32'hAA);
      rst       = 1'b0;
      h_phi2_en = 1'b0;
      p_phi2_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; h_phi2_en = 1'b0; h_selectData = 1'b0; h_rdnw = 1'b1; h_data = 8'h00;
      p_phi2_en = 1'b0; p_selectData = 1'b0; p_rd = 1'b0; p_two_byte = 1'b0;
      @(posedge clk);
      do_reset(1'b0);

      // Basic ordering
      cycle("push11", 1, 0, 8'h11);
      check("first_byte_visible", 32'(p_data), 32'h11);
      cycle("push22", 1, 0, 8'h22);
      cycle("push33", 1, 0, 8'h33);
      for (int i = 0; i < 3; i++) cycle("pop3", 0, 1, 8'h00);
      check("drained_avail", 32'(p_data_available), 32'd0);
      check("drained_data",  32'(p_data), 32'hAA);

      // Fill, overflow, drain
      do_reset(1'b0);
      for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 0, 8'(8'h40 + i));
      check("fill_full", 32'(h_full), 32'd1);
      cycle("push17", 1, 0, 8'hFF);
      check("ovf_set",   32'(h_overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd16);
      for (int i = 0; i < DEPTH; i++) cycle("drain", 0, 1, 8'h00);
      cycle("ovf_sticky_idle", 0, 0, 8'h00);

      // Push and pop together while full
      do_reset(1'b0);
      for (int i = 0; i < DEPTH; i++) cycle("fill2", 1, 0, 8'(i));
      cycle("full_pushpop", 1, 1, 8'h5A);
      check("full_pushpop_count", 32'(count), 32'd16);
      check("full_pushpop_noovf", 32'(h_overflow), 32'd0);
      for (int i = 0; i < DEPTH - 1; i++) cycle("drain2", 0, 1, 8'h00);
      check("5a_is_16th", 32'(p_data), 32'h5A);

      // Empty edge cases
      do_reset(1'b0);
      cycle("pop_empty", 0, 1, 8'h00);
      cycle("pushpop_empty", 1, 1, 8'h77);
      check("pushpop_empty_count", 32'(count), 32'd1);

      // Pointer wrap with mixed traffic
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) cycle("wrap_pre", 1, 0, 8'($urandom));
      for (int i = 0; i < 20; i++) cycle("wrap", 1, 1, 8'($urandom));
      for (int i = 0; i < 10; i++) cycle("wrap_more", 1, 0, 8'($urandom));

      // Random traffic, including non-qualifying strobe combinations and the pair-mode input
      do_reset(1'b0);
      for (int i = 0; i < 600; i++) begin
         int push_bias;
         push_bias  = ((i / 100) % 2 == 0) ? 80 : 25;
         p_two_byte = 1'($urandom_range(0, 1));
         drive("random",
               $urandom_range(0, 99) < push_bias, $urandom_range(0, 9) != 0,
               $urandom_range(0, 9) == 0, 8'($urandom),
               $urandom_range(0, 99) < (100 - push_bias), $urandom_range(0, 9) != 0,
               $urandom_range(0, 9) != 0);
      end
      p_two_byte = 1'b0;

      // Flush mid-operation with activity in the reset cycle
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) cycle("pre_flush", 1, 0, 8'(8'hC0 + i));
      check("pre_flush_count", 32'(count), 32'd5);
      do_reset(1'b1);
      check("flush_avail", 32'(p_data_available), 32'd0);

`ifdef HP_FIFO_TWO_BYTE_EN
      p_two_byte = 1'b1;
      cycle("pair_push01", 1, 0, 8'h01);
      check("pair_one_byte", 32'(p_data_available), 32'd0);
      cycle("pair_push02", 1, 0, 8'h02);
      check("pair_two_bytes", 32'(p_data_available), 32'd1);
      for (int i = 0; i < DEPTH - 3; i++) cycle("pair_fill", 1, 0, 8'(i));
      check("pair_15_full", 32'(h_full), 32'd1);
      cycle("pair_push16", 1, 0, 8'h99);
      p_two_byte = 1'b0;
      #1;
      check_outputs("pair_off");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
